cpu_control: RTL and testbench

Multi-cycle fetch/decode/execute controller for the simple 8-bit CPU, sitting directly upstream of the 4x8 register file.
- Holds PC, IR, FSM, result register, flags and a small internal ALU.
- Fetches from an asynchronous-read instruction ROM.
- Drives the register file's read addresses and consumes its two read ports.
- Produces write_addr / write_data / write_en for the register file's write port.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/cpu_alu.sv | 27 ++
 rtl/cpu_control.sv | 110 +++++++++++
 tb/tb_cpu_control.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared ISA encodings, IR field layout and FSM state type for the 8-bit CPU controller.
package cpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;
    localparam logic [1:0] OP_SYS = 2'b11;

    localparam logic [1:0] SYS_NOP  = 2'b00;
    localparam logic [1:0] SYS_HALT = 2'b01;
    localparam logic [1:0] SYS_JMPR = 2'b10;

    // IR layout: [7:6] op, [5:4] rd, [3:2] rs / sub-op, [1:0] unused
    localparam int IR_OP_LSB = 6;
    localparam int IR_RD_LSB = 4;
    localparam int IR_RS_LSB = 2;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXEC      = 3'd2,
        ST_IMM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    function automatic logic [1:0] ir_op(input logic [7:0] ir);
        return ir[IR_OP_LSB +: 2];
    endfunction

    function automatic logic [1:0] ir_rd(input logic [7:0] ir);
        return ir[IR_RD_LSB +: 2];
    endfunction

    function automatic logic [1:0] ir_rs(input logic [7:0] ir);
        return ir[IR_RS_LSB +: 2];
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ADD/SUB unit; carry is the add carry-out or the subtract borrow.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] op,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero
);

    logic [8:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        result = sum[7:0];
        carry  = sum[8];
        if (op == OP_SUB) begin
            result = a - b;
            carry  = (a < b);
        end
        zero = (result == 8'h00);
    end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle fetch/decode/execute controller driving a 4x8 register file.
// Register read data is only consumed in DECODE (JMPR) and EXEC.
module cpu_control
    import cpu_pkg::*;
#(
    parameter int          PC_WIDTH = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] instr_addr,
    input  logic [7:0]          instr_data,
    output logic [1:0]          read_addr_a,
    output logic [1:0]          read_addr_b,
    input  logic [7:0]          read_data_a,
    input  logic [7:0]          read_data_b,
    output logic [1:0]          write_addr,
    output logic [7:0]          write_data,
    output logic                write_en,
    output logic                zero_flag,
    output logic                carry_flag,
    output logic                halted
);

    localparam logic [PC_WIDTH-1:0] PC_INIT = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [7:0]          ir;
    logic [7:0]          result;
    logic                zero_q;
    logic                carry_q;

    logic [7:0]          alu_result;
    logic                alu_carry;
    logic                alu_zero;

    cpu_alu u_alu (
        .a      (read_data_a),
        .b      (read_data_b),
        .op     (ir_op(ir)),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_FETCH;
            pc      <= PC_INIT;
            ir      <= 8'h00;
            result  <= 8'h00;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    ir    <= instr_data;
                    pc    <= pc + PC_ONE;
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    case (ir_op(ir))
                        OP_ADD, OP_SUB: state <= ST_EXEC;
                        OP_LDI:         state <= ST_IMM;
                        default: begin
                            case (ir_rs(ir))
                                SYS_HALT: state <= ST_HALT;
                                SYS_JMPR: begin
                                    pc    <= PC_WIDTH'(read_data_a);
                                    state <= ST_FETCH;
                                end
                                default:  state <= ST_FETCH;
                            endcase
                        end
                    endcase
                end
                ST_EXEC: begin
                    result  <= alu_result;
                    carry_q <= alu_carry;
                    zero_q  <= alu_zero;
                    state   <= ST_WRITEBACK;
                end
                ST_IMM: begin
                    // Immediate byte sits at the already-incremented PC; flags are untouched.
                    result <= instr_data;
                    pc     <= pc + PC_ONE;
                    state  <= ST_WRITEBACK;
                end
                ST_WRITEBACK: state <= ST_FETCH;
                ST_HALT:      state <= ST_HALT;
                default:      state <= ST_FETCH;
            endcase
        end
    end

    // Decoded straight from the state register so reset drops write_en without a clock edge.
    assign write_en    = (state == ST_WRITEBACK);
    assign halted      = (state == ST_HALT);

    assign instr_addr  = pc;
    assign read_addr_a = ir_rd(ir);
    assign read_addr_b = ir_rs(ir);
    assign write_addr  = ir_rd(ir);
    assign write_data  = result;
    assign zero_flag   = zero_q;
    assign carry_flag  = carry_q;

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control with a behavioural ROM and 4x8 register file model.
module tb_cpu_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instr_addr;
    logic [7:0] instr_data;
    logic [1:0] read_addr_a;
    logic [1:0] read_addr_b;
    logic [7:0] read_data_a;
    logic [7:0] read_data_b;
    logic [1:0] write_addr;
    logic [7:0] write_data;
    logic       write_en;
    logic       zero_flag;
    logic       carry_flag;
    logic       halted;

    logic [7:0] rom [256];
    logic [7:0] regs [4];
    logic       regs_clear;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_control #(.PC_WIDTH(8), .RESET_PC(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_addr  (instr_addr),
        .instr_data  (instr_data),
        .read_addr_a (read_addr_a),
        .read_addr_b (read_addr_b),
        .read_data_a (read_data_a),
        .read_data_b (read_data_b),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .write_en    (write_en),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .halted      (halted)
    );

    assign instr_data  = rom[instr_addr];
    assign read_data_a = regs[read_addr_a];
    assign read_data_b = regs[read_addr_b];

    always @(posedge clk) begin
        if (regs_clear) begin
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
        end else if (write_en) begin
            regs[write_addr] <= write_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_nops();
        for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
    endtask

    task automatic do_reset(input bit clr);
        reset      = 1'b1;
        regs_clear = clr;
        tick(2);
        reset      = 1'b0;
        regs_clear = 1'b0;
    endtask

    task automatic test_reset();
        load_nops();
        reset = 1'b1;
        regs_clear = 1'b1;
        #1;
        n_checks++; if (instr_addr !== 8'h00) begin n_fail++; $display("FAIL rst_pc: got %h expected 00", instr_addr); end
        n_checks++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b expected 0", write_en); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b expected 0", halted); end
        n_checks++; if (write_data !== 8'h00) begin n_fail++; $display("FAIL rst_wdata: got %h expected 00", write_data); end
        n_checks++; if ({read_addr_a, read_addr_b, write_addr} !== 6'b0) begin n_fail++; $display("FAIL rst_addrs: got %b expected 000000", {read_addr_a, read_addr_b, write_addr}); end
        n_checks++; if ({zero_flag, carry_flag} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b expected 00", {zero_flag, carry_flag}); end
        tick(2);
        reset = 1'b0;
        regs_clear = 1'b0;
        tick(5);
        n_checks++; if (instr_addr !== 8'h03) begin n_fail++; $display("FAIL nop_run_pc: got %h expected 03", instr_addr); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (instr_addr !== 8'h00) begin n_fail++; $display("FAIL midrun_rst_pc: got %h expected 00", instr_addr); end
        n_checks++; if (write_en !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_outs: got we=%b halted=%b expected 0 0", write_en, halted); end
        tick(1);
        reset = 1'b0;
        tick(1);
        n_checks++; if (instr_addr !== 8'h01) begin n_fail++; $display("FAIL post_rst_pc1: got %h expected 01", instr_addr); end
        tick(2);
        n_checks++; if (instr_addr !== 8'h02) begin n_fail++; $display("FAIL post_rst_pc2: got %h expected 02", instr_addr); end
        tick(2);
        n_checks++; if (instr_addr !== 8'h03) begin n_fail++; $display("FAIL post_rst_pc3: got %h expected 03", instr_addr); end
    endtask

    task automatic test_ldi();
        load_nops();
        rom[0] = 8'h90;
        rom[1] = 8'h05;
        do_reset(1'b1);
        tick(2);
        n_checks++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL ldi_early_we: got %b expected 0", write_en); end
        tick(1);
        n_checks++; if (write_en !== 1'b1) begin n_fail++; $display("FAIL ldi_we: got %b expected 1", write_en); end
        n_checks++; if (write_addr !== 2'd1) begin n_fail++; $display("FAIL ldi_waddr: got %0d expected 1", write_addr); end
        n_checks++; if (write_data !== 8'h05) begin n_fail++; $display("FAIL ldi_wdata: got %h expected 05", write_data); end
        n_checks++; if (instr_addr !== 8'h02) begin n_fail++; $display("FAIL ldi_pc: got %h expected 02", instr_addr); end
        tick(1);
        n_checks++; if (regs[1] !== 8'h05) begin n_fail++; $display("FAIL ldi_r1: got %h expected 05", regs[1]); end
        n_checks++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL ldi_we_drop: got %b expected 0", write_en); end
    endtask

    task automatic test_add_carry();
        load_nops();
        rom[0] = 8'h90; rom[1] = 8'h05;
        rom[2] = 8'hA0; rom[3] = 8'hFC;
        rom[4] = 8'h18;
        rom[5] = 8'h54;
        rom[6] = 8'hC4;
        do_reset(1'b1);
        tick(12);
        n_checks++; if (regs[1] !== 8'h01) begin n_fail++; $display("FAIL add_r1: got %h expected 01", regs[1]); end
        n_checks++; if (regs[2] !== 8'hFC) begin n_fail++; $display("FAIL add_r2: got %h expected fc", regs[2]); end
        n_checks++; if (carry_flag !== 1'b1) begin n_fail++; $display("FAIL add_carry: got %b expected 1", carry_flag); end
        n_checks++; if (zero_flag !== 1'b0) begin n_fail++; $display("FAIL add_zero: got %b expected 0", zero_flag); end
        n_checks++; if (instr_addr !== 8'h05) begin n_fail++; $display("FAIL add_pc: got %h expected 05", instr_addr); end
    endtask

    task automatic test_sub_halt();
        int we_seen;
        int pc_moves;
        int halt_drops;
        tick(4);
        n_checks++; if (regs[1] !== 8'h00) begin n_fail++; $display("FAIL sub_r1: got %h expected 00", regs[1]); end
        n_checks++; if (zero_flag !== 1'b1) begin n_fail++; $display("FAIL sub_zero: got %b expected 1", zero_flag); end
        n_checks++; if (carry_flag !== 1'b0) begin n_fail++; $display("FAIL sub_borrow: got %b expected 0", carry_flag); end
        tick(1);
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_early: got %b expected 0", halted); end
        tick(1);
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_entry: got %b expected 1", halted); end
        n_checks++; if (instr_addr !== 8'h07) begin n_fail++; $display("FAIL halt_pc: got %h expected 07", instr_addr); end
        we_seen = 0;
        pc_moves = 0;
        halt_drops = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (write_en !== 1'b0) we_seen++;
            if (instr_addr !== 8'h07) pc_moves++;
            if (halted !== 1'b1) halt_drops++;
        end
        n_checks++; if (we_seen !== 0) begin n_fail++; $display("FAIL halt_we_count: got %0d expected 0", we_seen); end
        n_checks++; if (pc_moves !== 0) begin n_fail++; $display("FAIL halt_pc_frozen: got %0d moves expected 0", pc_moves); end
        n_checks++; if (halt_drops !== 0) begin n_fail++; $display("FAIL halt_held: got %0d drops expected 0", halt_drops); end
    endtask

    task automatic test_jmpr_wrap();
        load_nops();
        rom[0]    = 8'h33;
        rom[1]    = 8'hB0; rom[2] = 8'hFE;
        rom[3]    = 8'hF8;
        rom[8'hFE] = 8'hC0;
        rom[8'hFF] = 8'h90;
        do_reset(1'b1);
        tick(4);
        n_checks++; if (zero_flag !== 1'b1 || carry_flag !== 1'b0) begin n_fail++; $display("FAIL add0_flags: got z=%b c=%b expected 1 0", zero_flag, carry_flag); end
        tick(4);
        n_checks++; if (regs[3] !== 8'hFE) begin n_fail++; $display("FAIL jmp_r3: got %h expected fe", regs[3]); end
        tick(1);
        n_checks++; if (read_addr_a !== 2'd3) begin n_fail++; $display("FAIL jmp_raddr: got %0d expected 3", read_addr_a); end
        tick(1);
        n_checks++; if (instr_addr !== 8'hFE) begin n_fail++; $display("FAIL jmp_target: got %h expected fe", instr_addr); end
        tick(2);
        n_checks++; if (instr_addr !== 8'hFF) begin n_fail++; $display("FAIL nop_ff: got %h expected ff", instr_addr); end
        tick(1);
        n_checks++; if (instr_addr !== 8'h00) begin n_fail++; $display("FAIL fetch_wrap: got %h expected 00", instr_addr); end
        tick(2);
        n_checks++; if (write_en !== 1'b1 || write_data !== 8'h33 || write_addr !== 2'd1) begin n_fail++; $display("FAIL wrap_ldi_wb: got we=%b data=%h addr=%0d expected 1 33 1", write_en, write_data, write_addr); end
        n_checks++; if (instr_addr !== 8'h01) begin n_fail++; $display("FAIL imm_wrap_pc: got %h expected 01", instr_addr); end
        tick(1);
        n_checks++; if (regs[1] !== 8'h33) begin n_fail++; $display("FAIL wrap_r1: got %h expected 33", regs[1]); end
        n_checks++; if (zero_flag !== 1'b1) begin n_fail++; $display("FAIL ldi_keeps_flags: got %b expected 1", zero_flag); end
    endtask

    task automatic test_reset_in_writeback();
        load_nops();
        rom[0] = 8'h90; rom[1] = 8'h05;
        rom[2] = 8'hA0; rom[3] = 8'h07;
        rom[4] = 8'h18;
        do_reset(1'b1);
        tick(11);
        n_checks++; if (write_en !== 1'b1 || write_data !== 8'h0C) begin n_fail++; $display("FAIL wb_before_rst: got we=%b data=%h expected 1 0c", write_en, write_data); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL wb_rst_we: got %b expected 0", write_en); end
        n_checks++; if (write_data !== 8'h00 || instr_addr !== 8'h00) begin n_fail++; $display("FAIL wb_rst_state: got data=%h pc=%h expected 00 00", write_data, instr_addr); end
        tick(2);
        n_checks++; if (regs[1] !== 8'h05) begin n_fail++; $display("FAIL wb_rst_r1: got %h expected 05", regs[1]); end
        n_checks++; if (regs[2] !== 8'h07) begin n_fail++; $display("FAIL wb_rst_r2: got %h expected 07", regs[2]); end
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        regs_clear = 1'b1;
        test_reset();
        test_ldi();
        test_add_carry();
        test_sub_halt();
        test_jmpr_wrap();
        test_reset_in_writeback();
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
